// File: rtl/clk_div_pkg.sv
// Shared definitions for the even-ratio clock divider: default ratio and
// the half-period counter width helper.
package clk_div_pkg;

    localparam int unsigned DEFAULT_DIV_N = 6;

    // Width needed to count 0 .. ratio/2-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned ratio);
        int unsigned w;
        w = $clog2(ratio / 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/even_freq_divide_half_period_counter.sv
// Modulo-(DIV_N/2) up-counter with asynchronous active-low clear; tc marks
// the last count of each half period.
module half_period_counter
    import clk_div_pkg::*;
#(
    parameter  int unsigned DIV_N = DEFAULT_DIV_N,
    localparam int unsigned CNT_W = cnt_width(DIV_N)
) (
    input  logic clk,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_N / 2 - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Anything at or beyond LAST (including unreachable codes) wraps to 0.
    always_comb begin
        cnt_d = '0;
        if (cnt_q < LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAST);

endmodule

// File: rtl/even_freq_divide.sv
// Even-ratio 50 % duty clock divider (f_clk / DIV_N), output straight from a flop.
// Define EVEN_FREQ_DIVIDE_TICK_EN to add a one-cycle `tick` on each rising output edge.
module even_freq_divide
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_N = DEFAULT_DIV_N
) (
    input  logic clk,
    input  logic clr,
    output logic divideed_clk
`ifdef EVEN_FREQ_DIVIDE_TICK_EN
    ,
    output logic tick
`endif
);

    if (((DIV_N % 2) != 0) || (DIV_N < 2)) begin : g_bad_div_n
        $error("even_freq_divide: DIV_N must be even and >= 2");
    end

    logic tc;
    logic div_q;
    logic div_d;

    half_period_counter #(
        .DIV_N(DIV_N)
    ) u_hpc (
        .clk(clk),
        .clr(clr),
        .tc (tc)
    );

    always_comb begin
        div_d = div_q;
        if (tc) begin
            div_d = ~div_q;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_d;
        end
    end

    assign divideed_clk = div_q;

`ifdef EVEN_FREQ_DIVIDE_TICK_EN
    logic tick_q;
    logic tick_d;

    // Registered alongside div_q so it is high in the same cycle the output rises.
    always_comb begin
        tick_d = tc & ~div_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`endif

endmodule

// File: tb/tb_even_freq_divide.sv
// Directed bench for even_freq_divide at DIV_N = 6, 2 and 8 sharing one clock/reset.
module tb_even_freq_divide;

    logic clk;
    logic clr;
    logic out6;
    logic out2;
    logic out8;
`ifdef EVEN_FREQ_DIVIDE_TICK_EN
    logic tick6;
    logic tick2;
    logic tick8;
`endif

    int unsigned n_tests;
    int unsigned n_fail;

    even_freq_divide #(.DIV_N(6)) dut6 (
        .clk(clk), .clr(clr), .divideed_clk(out6)
`ifdef EVEN_FREQ_DIVIDE_TICK_EN
        , .tick(tick6)
`endif
    );

    even_freq_divide #(.DIV_N(2)) dut2 (
        .clk(clk), .clr(clr), .divideed_clk(out2)
`ifdef EVEN_FREQ_DIVIDE_TICK_EN
        , .tick(tick2)
`endif
    );

    even_freq_divide #(.DIV_N(8)) dut8 (
        .clk(clk), .clr(clr), .divideed_clk(out8)
`ifdef EVEN_FREQ_DIVIDE_TICK_EN
        , .tick(tick8)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One record per falling-edge sample after reset release (rises at 10, 30, 50 ns ...).
    typedef struct {
        logic exp6;
        logic exp2;
        logic tick6;
        logic [1:0] cnt6;
    } vec_t;

    vec_t vecs[12];

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'd1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'd2};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'd1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 2'd0};

        // Reset hold with no clock edges yet.
        clr = 1'b0;
        #1;
        check("reset_out6", 32'(out6), 32'd0);
        check("reset_out2", 32'(out2), 32'd0);
        check("reset_out8", 32'(out8), 32'd0);
        check("reset_cnt6", 32'(dut6.u_hpc.cnt_q), 32'd0);
`ifdef EVEN_FREQ_DIVIDE_TICK_EN
        check("reset_tick6", 32'(tick6), 32'd0);
`endif
        #4 clr = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_out6", i), 32'(out6), 32'(vecs[i].exp6));
            check($sformatf("vec%0d_out2", i), 32'(out2), 32'(vecs[i].exp2));
            check($sformatf("vec%0d_cnt6", i), 32'(dut6.u_hpc.cnt_q), 32'(vecs[i].cnt6));
            check($sformatf("vec%0d_cnt2", i), 32'(dut2.u_hpc.cnt_q), 32'd0);
`ifdef EVEN_FREQ_DIVIDE_TICK_EN
            check($sformatf("vec%0d_tick6", i), 32'(tick6), 32'(vecs[i].tick6));
`endif
        end

        // Wait (bounded) for the 6-divider to be high, then clear mid-cycle.
        begin
            int unsigned waited;
            waited = 0;
            while (out6 !== 1'b1 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            check("wait_out6_high", 32'(out6), 32'd1);
        end
        #3 clr = 1'b0;
        #1;
        check("async_clr_out6", 32'(out6), 32'd0);
        check("async_clr_cnt6", 32'(dut6.u_hpc.cnt_q), 32'd0);
        @(negedge clk);
        check("clr_hold_out6", 32'(out6), 32'd0);
        check("clr_hold_out2", 32'(out2), 32'd0);
        #5 clr = 1'b1;
        @(negedge clk);
        check("restart1_out6", 32'(out6), 32'd0);
        @(negedge clk);
        check("restart2_out6", 32'(out6), 32'd0);
        @(negedge clk);
        check("restart3_out6", 32'(out6), 32'd1);
`ifdef EVEN_FREQ_DIVIDE_TICK_EN
        check("restart3_tick6", 32'(tick6), 32'd1);
        @(negedge clk);
        check("restart4_tick6", 32'(tick6), 32'd0);
`endif

        // Long run: 100 output periods of the 8-divider from a fresh release.
        @(negedge clk);
        #2 clr = 1'b0;
        #5 clr = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            check($sformatf("run%0d_out8", k), 32'(out8), 32'((k / 4) % 2));
            check($sformatf("run%0d_cnt8", k), 32'(dut8.u_hpc.cnt_q), 32'(k % 4));
            if (k <= 24) begin
                check($sformatf("run%0d_out6", k), 32'(out6), 32'((k / 3) % 2));
                check($sformatf("run%0d_out2", k), 32'(out2), 32'(k % 2));
`ifdef EVEN_FREQ_DIVIDE_TICK_EN
                check($sformatf("run%0d_tick8", k), 32'(tick8), 32'((k % 8) == 4));
`endif
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/even_freq_divide.md
Name: even_freq_divide

Overview:
- Even-ratio clock divider: produces a 50 % duty-cycle output clock at f_clk / DIV_N, where DIV_N is an even integer.
- Sits at the clock-generation edge of the design; it derives slow clocks or strobes from the system clock.
- Fully synchronous to `clk`, except for the reset.

Parameters:
- DIV_N, 6, division ratio. Must be even and ≥ 2. The output period is DIV_N cycles of `clk`.
- CNT_W, derived as max(1, $clog2(DIV_N/2)), width of the internal half-period counter. Not user-overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-low (0 = reset asserted).
- divideed_clk  output  1  divided clock, registered, 50 % duty cycle.

Interface note: one clock; reset is asynchronous and active-low (ports `clk` and `clr`).

Behaviour:
- Reset (clr = 0, any time, asynchronous):
  - Half-period counter `cnt` is 0.
  - `divideed_clk` is 0.
  - Both hold while `clr` = 0.
- Normal operation (clr = 1), on each rising edge of `clk`:
  - If `cnt` == DIV_N/2 − 1: `cnt` ← 0 and `divideed_clk` ← ~`divideed_clk`.
  - Otherwise: `cnt` ← `cnt` + 1 and `divideed_clk` holds.
- First toggle (0 → 1) occurs on the (DIV_N/2)-th rising edge after `clr` deasserts. Later toggles occur every DIV_N/2 edges.
- Steady state: high for DIV_N/2 clk periods, low for DIV_N/2 clk periods. Exact 50 % duty, no glitches, since the output comes straight from a flop.
- DIV_N = 2: the output toggles on every rising edge (f_clk/2). The counter stays at 0.
- Counter wrap: `cnt` never exceeds DIV_N/2 − 1. Unreachable values (if CNT_W is wider than needed) return to 0 on the next edge.
- Reset mid-operation: the output drops to 0 immediately, regardless of phase. After release, the sequence restarts from the beginning.
- Illegal DIV_N (odd or < 2): elaboration-time error via a generate-time check. No silent rounding.

Optional Feature:
- Macro: EVEN_FREQ_DIVIDE_TICK_EN.
- Defined:
  - Adds output port `tick` (1 bit, registered).
  - `tick` is high for exactly one clk cycle, coincident with each 0 → 1 transition of `divideed_clk`, i.e. once per DIV_N cycles.
  - `tick` resets to 0.
  - Intended as a clock-enable for logic that stays on `clk`.
- Undefined: no `tick` port and no extra flop. Behaviour is otherwise identical.

Decomposition:
- Shared package `clk_div_pkg`:
  - function computing CNT_W from a ratio.
  - localparam default DIV_N = 6.
- One natural sub-module: `half_period_counter`.
  - Parameterised modulo-(DIV_N/2) up-counter with async active-low clear.
  - Emits a terminal-count pulse.
- Top level:
  - instantiates `half_period_counter`;
  - holds the output toggle flop;
  - holds the optional `tick` flop.

Test Plan:
1. Reset hold, DIV_N = 6, clk period 20 ns: `clr` = 0 for 5 ns → `divideed_clk` = 0 and `cnt` = 0, with no clk edges needed.
2. Release at 5 ns, first clk rise at 10 ns, DIV_N = 6 → `divideed_clk` rises at 50 ns, falls at 110 ns, rises at 170 ns. Period 120 ns; high and low 60 ns each.
3. DIV_N = 2 → output toggles on every clk rise; period 40 ns with a 20 ns clk period.
4. Assert `clr` = 0 asynchronously while the output is high (DIV_N = 6) → output goes to 0 immediately. After release, the first rise comes 3 clk edges later.
5. DIV_N = 8 run for 100 output periods → every high and low phase is exactly 4 clk cycles; `cnt` stays within 0..3.
6. With EVEN_FREQ_DIVIDE_TICK_EN, DIV_N = 6 → `tick` is high for one cycle at 50 ns and 170 ns, low otherwise. Without the macro, the build has no `tick` port.
